por_rst_seq: RTL and testbench

- Digital consumer of the POR's reset output: takes the active-low porb plus an asynchronous supply-good level and releases NUM_DOM downstream active-low domain resets in a fixed order.
- Each domain is released after a programmable delay.
- Re-asserts all domain resets on brownout or on a software reset handshake.
- Sits in the dvdd domain directly after the por block, clocked by osc_ck.

---
 rtl/por_rst_seq_if.sv | 24 ++
 rtl/por_rst_seq.sv | 194 +++++++++++++++++++
 tb/tb_por_rst_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/por_rst_seq_if.sv
// rtl/por_rst_seq_if.sv - control/status bundle of the reset sequencer
// Carries the software reset handshake and the sequenced reset / status outputs.
interface por_rst_seq_if #(
  parameter int NUM_DOM = 3,
  parameter int CNT_W   = 8
);
  logic               sw_rst_req;
  logic               sw_rst_ack;
  logic [NUM_DOM-1:0] rstb_out;
  logic               seq_done;
  logic [1:0]         seq_state;
  logic               brownout_evt;
  logic [CNT_W-1:0]   evt_cnt;

  modport master (
    output sw_rst_req,
    input  sw_rst_ack, rstb_out, seq_done, seq_state, brownout_evt, evt_cnt
  );

  modport slave (
    input  sw_rst_req,
    output sw_rst_ack, rstb_out, seq_done, seq_state, brownout_evt, evt_cnt
  );
endinterface

// File: rtl/por_rst_seq.sv
// rtl/por_rst_seq.sv - ordered release of domain resets after POR, with brownout and software reset
// Optional run-time watchdog is built when POR_SEQ_WDT_EN is defined.
module por_rst_seq #(
  parameter int NUM_DOM     = 3,
  parameter int DLY_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 8
`ifdef POR_SEQ_WDT_EN
  ,
  parameter int WDT_W       = 16
`endif
) (
  input  logic                     osc_ck,
  input  logic                     porb,
  input  logic                     pwr_ok,
  input  logic [NUM_DOM*DLY_W-1:0] dly_cfg,
`ifdef POR_SEQ_WDT_EN
  input  logic                     wdt_kick,
  output logic                     wdt_evt,
`endif
  por_rst_seq_if.slave             ctl
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int FC_W  = $clog2(FILT_LEN) + 1;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_SWRST   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FC_W-1:0]        filt_q, filt_d;
  logic                   pok_f_q, pok_f_d;
  logic [NUM_DOM-1:0]     rstb_q, rstb_d;
  logic                   seq_done_q, seq_done_d;
  logic                   ack_q, ack_d;
  logic                   bo_evt_q, bo_evt_d;
  logic [CNT_W-1:0]       evt_cnt_q, evt_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic                   wdt_fire;

`ifdef POR_SEQ_WDT_EN
  logic [WDT_W-1:0] wdt_q, wdt_d, wdt_inc;
  logic             wdt_evt_q, wdt_evt_d;

  assign wdt_inc  = wdt_q + 1'b1;
  assign wdt_fire = (state_q == S_RUN) && !wdt_kick && (&wdt_inc);
  assign wdt_evt  = wdt_evt_q;
`else
  assign wdt_fire = 1'b0;
`endif

  // pok_f only flips after FILT_LEN consecutive disagreeing samples
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pwr_ok};
    pok_f_d = pok_f_q;
    filt_d  = '0;
    if (sync_q[SYNC_STAGES-1] != pok_f_q) begin
      if (filt_q == FC_W'(FILT_LEN - 1)) pok_f_d = ~pok_f_q;
      else                               filt_d  = filt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rstb_d     = rstb_q;
    seq_done_d = seq_done_q;
    ack_d      = ack_q;
    bo_evt_d   = 1'b0;
    evt_cnt_d  = evt_cnt_q;
    idx_d      = idx_q;
    dly_d      = dly_q;
`ifdef POR_SEQ_WDT_EN
    wdt_d      = '0;
    wdt_evt_d  = 1'b0;
`endif
    case (state_q)
      S_HOLD: begin
        rstb_d     = '0;
        seq_done_d = 1'b0;
        ack_d      = 1'b0;
        if (pok_f_q) begin
          dly_d   = dly_cfg[DLY_W-1:0];
          idx_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (dly_q != '0) begin
          dly_d = dly_q - 1'b1;
        end else begin
          rstb_d[idx_q] = 1'b1;
          if (idx_q == IDX_W'(NUM_DOM - 1)) begin
            state_d    = S_RUN;
            seq_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            dly_d = dly_cfg[int'(idx_d)*DLY_W +: DLY_W];
          end
        end
      end
      S_RUN: begin
`ifdef POR_SEQ_WDT_EN
        wdt_d = wdt_kick ? '0 : wdt_inc;
`endif
        if (wdt_fire) begin
`ifdef POR_SEQ_WDT_EN
          wdt_d     = '0;
          wdt_evt_d = 1'b1;
`endif
          rstb_d     = '0;
          seq_done_d = 1'b0;
          state_d    = S_HOLD;
        end else if (ctl.sw_rst_req) begin
          rstb_d     = '0;
          seq_done_d = 1'b0;
          ack_d      = 1'b1;
          state_d    = S_SWRST;
        end
      end
      S_SWRST: begin
        if (!ctl.sw_rst_req) begin
          ack_d   = 1'b0;
          state_d = S_HOLD;
        end
      end
      default: state_d = S_HOLD;
    endcase

    // pok_f can only be low outside HOLD if it fell after HOLD was left
    if (state_q != S_HOLD && !pok_f_q) begin
      state_d    = S_HOLD;
      rstb_d     = '0;
      seq_done_d = 1'b0;
      ack_d      = 1'b0;
      bo_evt_d   = 1'b1;
      if (!(&evt_cnt_q)) evt_cnt_d = evt_cnt_q + 1'b1;
`ifdef POR_SEQ_WDT_EN
      wdt_d      = '0;
      wdt_evt_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge osc_ck or negedge porb) begin
    if (!porb) begin
      state_q    <= S_HOLD;
      sync_q     <= '0;
      filt_q     <= '0;
      pok_f_q    <= 1'b0;
      rstb_q     <= '0;
      seq_done_q <= 1'b0;
      ack_q      <= 1'b0;
      bo_evt_q   <= 1'b0;
      evt_cnt_q  <= '0;
      idx_q      <= '0;
      dly_q      <= '0;
`ifdef POR_SEQ_WDT_EN
      wdt_q      <= '0;
      wdt_evt_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      filt_q     <= filt_d;
      pok_f_q    <= pok_f_d;
      rstb_q     <= rstb_d;
      seq_done_q <= seq_done_d;
      ack_q      <= ack_d;
      bo_evt_q   <= bo_evt_d;
      evt_cnt_q  <= evt_cnt_d;
      idx_q      <= idx_d;
      dly_q      <= dly_d;
`ifdef POR_SEQ_WDT_EN
      wdt_q      <= wdt_d;
      wdt_evt_q  <= wdt_evt_d;
`endif
    end
  end

  assign ctl.rstb_out     = rstb_q;
  assign ctl.seq_done     = seq_done_q;
  assign ctl.sw_rst_ack   = ack_q;
  assign ctl.brownout_evt = bo_evt_q;
  assign ctl.evt_cnt      = evt_cnt_q;
  assign ctl.seq_state    = state_q;

endmodule

// File: tb/tb_por_rst_seq.sv
// tb/tb_por_rst_seq.sv - directed bench for por_rst_seq
// Define POR_SEQ_WDT_EN to also build and exercise the watchdog with WDT_W=4.
module tb_por_rst_seq;

  logic        osc_ck = 1'b0;
  logic        porb;
  logic        pwr_ok;
  logic [23:0] dly_cfg;
`ifdef POR_SEQ_WDT_EN
  logic        wdt_kick;
  logic        wdt_evt;
`endif
  int vec = 0;
  int err = 0;

  por_rst_seq_if #(.NUM_DOM(3), .CNT_W(8)) ctl ();

  por_rst_seq #(
    .NUM_DOM(3), .DLY_W(8), .SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(8)
`ifdef POR_SEQ_WDT_EN
    , .WDT_W(4)
`endif
  ) dut (
    .osc_ck  (osc_ck),
    .porb    (porb),
    .pwr_ok  (pwr_ok),
    .dly_cfg (dly_cfg),
`ifdef POR_SEQ_WDT_EN
    .wdt_kick(wdt_kick),
    .wdt_evt (wdt_evt),
`endif
    .ctl     (ctl)
  );

  always #5 osc_ck = ~osc_ck;

  task automatic tick(input int n);
    repeat (n) @(posedge osc_ck);
    #1;
  endtask

  task automatic test_reset;
    tick(2);
    vec++; if (ctl.rstb_out !== 3'b000) begin err++; $display("FAIL rst_rstb got=%b exp=000", ctl.rstb_out); end
    vec++; if (ctl.seq_done !== 1'b0) begin err++; $display("FAIL rst_done got=%b exp=0", ctl.seq_done); end
    vec++; if (ctl.sw_rst_ack !== 1'b0) begin err++; $display("FAIL rst_ack got=%b exp=0", ctl.sw_rst_ack); end
    vec++; if (ctl.brownout_evt !== 1'b0) begin err++; $display("FAIL rst_bo got=%b exp=0", ctl.brownout_evt); end
    vec++; if (ctl.evt_cnt !== 8'd0) begin err++; $display("FAIL rst_cnt got=%0d exp=0", ctl.evt_cnt); end
    vec++; if (ctl.seq_state !== 2'd0) begin err++; $display("FAIL rst_state got=%0d exp=0", ctl.seq_state); end
  endtask

  task automatic test_power_up;
    porb = 1'b1;
    dly_cfg = {8'd3, 8'd1, 8'd0};
    tick(10);
    pwr_ok = 1'b1;
    tick(7);
    vec++; if (ctl.rstb_out !== 3'b000 || ctl.seq_state !== 2'd1) begin err++; $display("FAIL pu_load rstb=%b st=%0d exp=000/1", ctl.rstb_out, ctl.seq_state); end
    tick(1);
    vec++; if (ctl.rstb_out !== 3'b001) begin err++; $display("FAIL pu_dom0 got=%b exp=001", ctl.rstb_out); end
    tick(1);
    vec++; if (ctl.rstb_out !== 3'b001) begin err++; $display("FAIL pu_dom1_early got=%b exp=001", ctl.rstb_out); end
    tick(1);
    vec++; if (ctl.rstb_out !== 3'b011) begin err++; $display("FAIL pu_dom1 got=%b exp=011", ctl.rstb_out); end
    tick(3);
    vec++; if (ctl.rstb_out !== 3'b011 || ctl.seq_done !== 1'b0) begin err++; $display("FAIL pu_dom2_early rstb=%b done=%b exp=011/0", ctl.rstb_out, ctl.seq_done); end
    tick(1);
    vec++; if (ctl.rstb_out !== 3'b111 || ctl.seq_done !== 1'b1 || ctl.seq_state !== 2'd2) begin err++; $display("FAIL pu_run rstb=%b done=%b st=%0d exp=111/1/2", ctl.rstb_out, ctl.seq_done, ctl.seq_state); end
  endtask

  task automatic test_glitch;
    pwr_ok = 1'b0;
    tick(3);
    pwr_ok = 1'b1;
    tick(10);
    vec++; if (ctl.rstb_out !== 3'b111 || ctl.evt_cnt !== 8'd0 || ctl.seq_state !== 2'd2) begin err++; $display("FAIL gl_short rstb=%b cnt=%0d st=%0d exp=111/0/2", ctl.rstb_out, ctl.evt_cnt, ctl.seq_state); end
    pwr_ok = 1'b0;
    tick(6);
    vec++; if (ctl.rstb_out !== 3'b111 || ctl.brownout_evt !== 1'b0) begin err++; $display("FAIL gl_pre rstb=%b bo=%b exp=111/0", ctl.rstb_out, ctl.brownout_evt); end
    tick(1);
    vec++; if (ctl.rstb_out !== 3'b000 || ctl.brownout_evt !== 1'b1 || ctl.evt_cnt !== 8'd1 || ctl.seq_state !== 2'd0 || ctl.seq_done !== 1'b0)
      begin err++; $display("FAIL gl_bo rstb=%b bo=%b cnt=%0d st=%0d done=%b exp=000/1/1/0/0", ctl.rstb_out, ctl.brownout_evt, ctl.evt_cnt, ctl.seq_state, ctl.seq_done); end
    tick(1);
    vec++; if (ctl.brownout_evt !== 1'b0) begin err++; $display("FAIL gl_pulse got=%b exp=0", ctl.brownout_evt); end
    pwr_ok = 1'b1;
    tick(7);
    vec++; if (ctl.rstb_out !== 3'b000) begin err++; $display("FAIL gl_reseq0 got=%b exp=000", ctl.rstb_out); end
    tick(1);
    vec++; if (ctl.rstb_out !== 3'b001) begin err++; $display("FAIL gl_reseq1 got=%b exp=001", ctl.rstb_out); end
    tick(2);
    vec++; if (ctl.rstb_out !== 3'b011) begin err++; $display("FAIL gl_reseq2 got=%b exp=011", ctl.rstb_out); end
    tick(4);
    vec++; if (ctl.rstb_out !== 3'b111 || ctl.seq_done !== 1'b1) begin err++; $display("FAIL gl_reseq3 rstb=%b done=%b exp=111/1", ctl.rstb_out, ctl.seq_done); end
  endtask

  task automatic test_sw_reset;
    ctl.sw_rst_req = 1'b1;
    tick(1);
    vec++; if (ctl.sw_rst_ack !== 1'b1 || ctl.rstb_out !== 3'b000 || ctl.seq_done !== 1'b0 || ctl.seq_state !== 2'd3)
      begin err++; $display("FAIL sw_enter ack=%b rstb=%b done=%b st=%0d exp=1/000/0/3", ctl.sw_rst_ack, ctl.rstb_out, ctl.seq_done, ctl.seq_state); end
    tick(4);
    vec++; if (ctl.sw_rst_ack !== 1'b1 || ctl.seq_state !== 2'd3) begin err++; $display("FAIL sw_hold ack=%b st=%0d exp=1/3", ctl.sw_rst_ack, ctl.seq_state); end
    ctl.sw_rst_req = 1'b0;
    tick(1);
    vec++; if (ctl.sw_rst_ack !== 1'b0 || ctl.seq_state !== 2'd0) begin err++; $display("FAIL sw_exit ack=%b st=%0d exp=0/0", ctl.sw_rst_ack, ctl.seq_state); end
    tick(1);
    vec++; if (ctl.seq_state !== 2'd1 || ctl.rstb_out !== 3'b000) begin err++; $display("FAIL sw_reload st=%0d rstb=%b exp=1/000", ctl.seq_state, ctl.rstb_out); end
    tick(1);
    vec++; if (ctl.rstb_out !== 3'b001) begin err++; $display("FAIL sw_dom0 got=%b exp=001", ctl.rstb_out); end
    tick(2);
    vec++; if (ctl.rstb_out !== 3'b011) begin err++; $display("FAIL sw_dom1 got=%b exp=011", ctl.rstb_out); end
    tick(4);
    vec++; if (ctl.rstb_out !== 3'b111 || ctl.seq_state !== 2'd2) begin err++; $display("FAIL sw_run rstb=%b st=%0d exp=111/2", ctl.rstb_out, ctl.seq_state); end
  endtask

  task automatic test_brownout;
    dly_cfg = {8'd20, 8'd20, 8'd0};
    ctl.sw_rst_req = 1'b1;
    tick(1);
    ctl.sw_rst_req = 1'b0;
    tick(3);
    vec++; if (ctl.rstb_out !== 3'b001 || ctl.seq_state !== 2'd1) begin err++; $display("FAIL bo_partial rstb=%b st=%0d exp=001/1", ctl.rstb_out, ctl.seq_state); end
    pwr_ok = 1'b0;
    tick(6);
    vec++; if (ctl.rstb_out !== 3'b001 || ctl.seq_state !== 2'd1) begin err++; $display("FAIL bo_pre rstb=%b st=%0d exp=001/1", ctl.rstb_out, ctl.seq_state); end
    tick(1);
    vec++; if (ctl.rstb_out !== 3'b000 || ctl.brownout_evt !== 1'b1 || ctl.evt_cnt !== 8'd2 || ctl.seq_state !== 2'd0)
      begin err++; $display("FAIL bo_release rstb=%b bo=%b cnt=%0d st=%0d exp=000/1/2/0", ctl.rstb_out, ctl.brownout_evt, ctl.evt_cnt, ctl.seq_state); end
    ctl.sw_rst_req = 1'b1;
    tick(3);
    vec++; if (ctl.sw_rst_ack !== 1'b0 || ctl.seq_state !== 2'd0) begin err++; $display("FAIL bo_req_hold ack=%b st=%0d exp=0/0", ctl.sw_rst_ack, ctl.seq_state); end
    dly_cfg = {8'd3, 8'd1, 8'd0};
    pwr_ok = 1'b1;
    tick(7);
    vec++; if (ctl.sw_rst_ack !== 1'b0 || ctl.seq_state !== 2'd1) begin err++; $display("FAIL bo_req_rel ack=%b st=%0d exp=0/1", ctl.sw_rst_ack, ctl.seq_state); end
    tick(7);
    vec++; if (ctl.rstb_out !== 3'b111 || ctl.seq_state !== 2'd2) begin err++; $display("FAIL bo_req_run rstb=%b st=%0d exp=111/2", ctl.rstb_out, ctl.seq_state); end
    tick(1);
    vec++; if (ctl.sw_rst_ack !== 1'b1 || ctl.seq_state !== 2'd3) begin err++; $display("FAIL bo_req_late ack=%b st=%0d exp=1/3", ctl.sw_rst_ack, ctl.seq_state); end
    ctl.sw_rst_req = 1'b0;
    tick(9);
    vec++; if (ctl.seq_state !== 2'd2) begin err++; $display("FAIL bo_rerun st=%0d exp=2", ctl.seq_state); end
    pwr_ok = 1'b0;
    tick(6);
    vec++; if (ctl.seq_state !== 2'd2) begin err++; $display("FAIL bo_same_pre st=%0d exp=2", ctl.seq_state); end
    ctl.sw_rst_req = 1'b1;
    tick(1);
    vec++; if (ctl.seq_state !== 2'd0 || ctl.sw_rst_ack !== 1'b0 || ctl.brownout_evt !== 1'b1 || ctl.evt_cnt !== 8'd3 || ctl.rstb_out !== 3'b000)
      begin err++; $display("FAIL bo_same st=%0d ack=%b bo=%b cnt=%0d rstb=%b exp=0/0/1/3/000", ctl.seq_state, ctl.sw_rst_ack, ctl.brownout_evt, ctl.evt_cnt, ctl.rstb_out); end
    ctl.sw_rst_req = 1'b0;
  endtask

  task automatic test_saturation;
    porb = 1'b0;
    pwr_ok = 1'b0;
    #1;
    vec++; if (ctl.evt_cnt !== 8'd0 || ctl.rstb_out !== 3'b000 || ctl.seq_state !== 2'd0) begin err++; $display("FAIL sat_async cnt=%0d rstb=%b st=%0d exp=0/000/0", ctl.evt_cnt, ctl.rstb_out, ctl.seq_state); end
    tick(1);
    porb = 1'b1;
    dly_cfg = {8'd20, 8'd20, 8'd0};
    for (int i = 0; i < 260; i++) begin
      pwr_ok = 1'b1;
      tick(8);
      pwr_ok = 1'b0;
      tick(8);
      if (i == 254) begin
        vec++; if (ctl.evt_cnt !== 8'd255) begin err++; $display("FAIL sat_255 got=%0d exp=255", ctl.evt_cnt); end
      end
    end
    vec++; if (ctl.evt_cnt !== 8'd255) begin err++; $display("FAIL sat_hold got=%0d exp=255", ctl.evt_cnt); end
    pwr_ok = 1'b1;
    tick(8);
    porb = 1'b0;
    #1;
    vec++; if (ctl.evt_cnt !== 8'd0 || ctl.rstb_out !== 3'b000 || ctl.seq_done !== 1'b0 || ctl.sw_rst_ack !== 1'b0 || ctl.brownout_evt !== 1'b0 || ctl.seq_state !== 2'd0)
      begin err++; $display("FAIL sat_porb cnt=%0d rstb=%b done=%b ack=%b bo=%b st=%0d exp=0/000/0/0/0/0", ctl.evt_cnt, ctl.rstb_out, ctl.seq_done, ctl.sw_rst_ack, ctl.brownout_evt, ctl.seq_state); end
    pwr_ok = 1'b0;
    tick(2);
  endtask

`ifdef POR_SEQ_WDT_EN
  task automatic test_wdt;
    porb = 1'b1;
    dly_cfg = {8'd3, 8'd1, 8'd0};
    pwr_ok = 1'b1;
    tick(14);
    vec++; if (ctl.seq_state !== 2'd2) begin err++; $display("FAIL wdt_run st=%0d exp=2", ctl.seq_state); end
    tick(14);
    vec++; if (wdt_evt !== 1'b0 || ctl.rstb_out !== 3'b111) begin err++; $display("FAIL wdt_pre evt=%b rstb=%b exp=0/111", wdt_evt, ctl.rstb_out); end
    tick(1);
    vec++; if (wdt_evt !== 1'b1 || ctl.rstb_out !== 3'b000 || ctl.seq_state !== 2'd0 || ctl.evt_cnt !== 8'd0)
      begin err++; $display("FAIL wdt_fire evt=%b rstb=%b st=%0d cnt=%0d exp=1/000/0/0", wdt_evt, ctl.rstb_out, ctl.seq_state, ctl.evt_cnt); end
    tick(1);
    vec++; if (wdt_evt !== 1'b0) begin err++; $display("FAIL wdt_pulse got=%b exp=0", wdt_evt); end
    tick(7);
    for (int k = 0; k < 5; k++) begin
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
      tick(9);
      vec++; if (ctl.rstb_out !== 3'b111 || ctl.seq_state !== 2'd2) begin err++; $display("FAIL wdt_kick%0d rstb=%b st=%0d exp=111/2", k, ctl.rstb_out, ctl.seq_state); end
    end
  endtask
`endif

  initial begin
    porb = 1'b0;
    pwr_ok = 1'b0;
    dly_cfg = '0;
    ctl.sw_rst_req = 1'b0;
`ifdef POR_SEQ_WDT_EN
    wdt_kick = 1'b0;
`endif
    test_reset();
    test_power_up();
    test_glitch();
    test_sw_reset();
    test_brownout();
    test_saturation();
`ifdef POR_SEQ_WDT_EN
    test_wdt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
